// File: rtl/psum_acc_8ch_pkg.sv
// Shared definitions for the 8-lane partial-sum accumulator and the quantiser wrapper.
// Holds the FSM encoding, default lane geometry and the int32 saturation bounds.
package psum_acc_8ch_pkg;

    localparam int CH_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int LW_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [DW_DEF-1:0] SAT_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam logic [DW_DEF-1:0] SAT_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/psum_acc_8ch_sat_add_lane.sv
// One accumulator lane: signed add at DW+1 bits, clamped back to DW bits.
// o_ovf flags that a clamp happened on this beat.
module sat_add_lane
    import psum_acc_8ch_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_sum,
    output logic          o_ovf
);

    logic [DW:0] w_wide;

    assign w_wide = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};

    // The two top bits disagree only when the true sum left the DW-bit signed range.
    always_comb begin
        o_sum = w_wide[DW-1:0];
        o_ovf = 1'b0;
        if (w_wide[DW] != w_wide[DW-1]) begin
            o_ovf = 1'b1;
            o_sum = w_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_acc_8ch.sv
// 8-lane int32 partial-sum accumulator feeding the int8 quantiser.
// Bias preload on start, saturating accumulation of acc_len beats, one-cycle result valid.
module psum_acc_8ch
    import psum_acc_8ch_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic            sclk,
    input  logic            s_rst_n,
    input  logic            start,
    input  logic [LW-1:0]   acc_len,
    input  logic [CH*DW-1:0] bias_in,
    input  logic [CH*DW-1:0] psum_in,
    input  logic            psum_vld,
    output logic [CH*DW-1:0] acc_out,
    output logic            acc_out_vld,
    output logic            busy,
    output logic            ovf
);

    state_t           r_state;
    state_t           w_nextState;
    logic [LW-1:0]    r_cnt;
    logic [LW-1:0]    r_len;
    logic [CH*DW-1:0] r_acc;
    logic [CH*DW-1:0] w_sum;
    logic [CH-1:0]    w_laneOvf;
    logic             r_vld;
    logic             r_ovf;
    logic             w_startAcc;
    logic             w_startZero;
    logic             w_beat;
    logic             w_lastBeat;

    assign w_startAcc  = (r_state == ST_IDLE) && start && (acc_len != '0);
    assign w_startZero = (r_state == ST_IDLE) && start && (acc_len == '0);
    assign w_beat      = (r_state == ST_ACC) && psum_vld;
    assign w_lastBeat  = w_beat && (r_cnt == (r_len - LW'(1)));

    for (genvar gLane = 0; gLane < CH; gLane++) begin : gLanes
        sat_add_lane #(
            .DW (DW)
        ) uLane (
            .i_a   (r_acc[gLane*DW +: DW]),
            .i_b   (psum_in[gLane*DW +: DW]),
            .o_sum (w_sum[gLane*DW +: DW]),
            .o_ovf (w_laneOvf[gLane])
        );
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startAcc) begin
                    w_nextState = ST_ACC;
                end
            end
            ST_ACC: begin
                busy = 1'b1;
                if (w_lastBeat) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Accumulator doubles as the output register; a zero-length start is just a bias pass-through.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_startAcc || w_startZero) begin
                r_acc <= bias_in;
                r_ovf <= 1'b0;
            end
            if (w_startAcc) begin
                r_len <= acc_len;
                r_cnt <= '0;
            end
            if (w_startZero) begin
                r_vld <= 1'b1;
            end
            if (w_beat) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | (|w_laneOvf);
                r_cnt <= r_cnt + LW'(1);
                if (w_lastBeat) begin
                    r_vld <= 1'b1;
                end
            end
        end
    end

    assign acc_out     = r_acc;
    assign acc_out_vld = r_vld;
    assign ovf         = r_ovf;

endmodule
